mmio_responder: RTL and testbench
=================================

# mmio_responder

Memory-mapped peripheral responder on the data-side memory interface: the target end of the CPU's load/store requests. It decodes requests in its address window, holds the requester with `stall` for a programmable latency, then completes reads and writes to a small register file of GPIO output, synchronized GPIO input, a 32-bit timer, and a compare/status pair. It sits beside the RAM/ROM paths in the memory controller and drives `output_peripherals` from `input_peripherals`.

## Interface
Parameters:
- `BASE_ADDR`, 32'h0000_2000, window base; window is 32 bytes, word aligned.
- `LATENCY`, 1, wait cycles per access (1..15).
- `DEBOUNCE_CYCLES`, 16, stable cycles required per input bit (debounce build only).

Ports:
- `clock` input 1: single clock, all state on posedge.
- `reset` input 1: asynchronous, active-high.
- `address` input 32: byte address of request.
- `input_data` input 32: write data.
- `mem_read` input 1: read request.
- `mem_write` input 1: write request.
- `output_data` output 32: read data, valid when state DONE.
- `stall` output 1: requester must hold request stable while high.
- `input_peripherals` input 4: asynchronous external inputs.
- `output_peripherals` output 4: GPIO_OUT[3:0].

## Operation
- `sel` = `address[31:5] == BASE_ADDR[31:5]`; `req` = `sel && (mem_read || mem_write)`.
- Register offsets (`address[4:2]`):
  - 0 GPIO_OUT: RW, bits [3:0], others read 0.
  - 1 GPIO_IN: RO, conditioned inputs in [3:0].
  - 2 TIMER: RW, +1 every cycle, wraps 0xFFFF_FFFF->0.
  - 3 TIMER_CMP: RW.
  - 4 STATUS: bit0 MATCH sticky; write 1 to bit0 clears; other bits read 0.
  - 5-7: read 0, writes ignored.
- FSM IDLE -> WAIT -> DONE -> IDLE:
  - IDLE: `req` -> WAIT, counter = LATENCY-1.
  - WAIT: counter 0 -> DONE, else decrement.
  - DONE: write commits on entering edge; `output_data` holds pre-write value; next edge -> IDLE.
  - `req` dropped in WAIT -> IDLE, no write committed.
- `stall` = `req && state != DONE`; 0 when `!sel`.
- Read+write both high: old value returned, new value committed (atomic RMW).
- MATCH sets when TIMER == TIMER_CMP; set beats same-cycle clear.
- Write to TIMER beats increment that cycle.

## Timing
- Reset: state IDLE, `output_data` 0, `stall` 0 while reset high, GPIO_OUT 0, TIMER 0, TIMER_CMP 32'hFFFF_FFFF, MATCH 0, input sync flops 0.
- Access latency: LATENCY+1 stall cycles; data/ack on cycle LATENCY+1 after request.
- `output_data` 0 outside DONE.
- GPIO_IN: 2-flop synchronizer, 2 cycles from pin to register.
- GPIO_OUT write visible on `output_peripherals` from DONE cycle onward.
- Reset mid-WAIT aborts access; no write committed.

## Configuration
- `MMIO_DEBOUNCE_EN` defined: each synchronized bit updates GPIO_IN only after DEBOUNCE_CYCLES consecutive equal samples; per-bit counter resets on change.
- Undefined: GPIO_IN is the synchronizer output directly; DEBOUNCE_CYCLES unused.

## Structure
- Shared package/header: offset constants `MMIO_GPIO_OUT`..`MMIO_STATUS`, FSM state encodings, `MMIO_STATUS_MATCH` bit index.
- One sub-module: `input_debounce` (synchronizer plus optional debounce, one instance per bit).

## Test plan
- Reset, LATENCY=1: write 0xA to BASE+0 -> `stall` high 2 cycles, `output_peripherals`=4'hA; read BASE+0 -> `output_data`=0x0000_000A.
- `input_peripherals`=4'h5 held; read BASE+4 -> 0x5 (no debounce build), 0x5 only after 16 stable cycles (debounce build); 8-cycle glitch to 4'h0 -> unchanged.
- Write TIMER=0xFFFF_FFFE, TIMER_CMP=0x0000_0001 -> wrap, MATCH=1 three cycles later; write STATUS=1 -> MATCH reads 0.
- Both read+write to BASE+12 with 0x55, old 0x33 -> `output_data`=0x33, later read 0x55.
- Request to BASE+0x20 -> `stall`=0, `output_data`=0; BASE+0x1C read -> 0.
- `req` dropped mid-WAIT (LATENCY=4) write 0xF to GPIO_OUT -> `output_peripherals` unchanged; reset mid-WAIT -> IDLE, `stall`=0.

Source files
------------

// File: rtl/mmio_responder_pkg.sv
// Shared definitions for the MMIO responder: register offsets, FSM states, STATUS bit layout.
package mmio_responder_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [2:0] MMIO_GPIO_OUT  = 3'd0;
  localparam logic [2:0] MMIO_GPIO_IN   = 3'd1;
  localparam logic [2:0] MMIO_TIMER     = 3'd2;
  localparam logic [2:0] MMIO_TIMER_CMP = 3'd3;
  localparam logic [2:0] MMIO_STATUS    = 3'd4;

  localparam int MMIO_STATUS_MATCH = 0;
endpackage

// File: rtl/mmio_responder_input_debounce.sv
// One GPIO input bit: 2-flop synchronizer, plus a stability filter when MMIO_DEBOUNCE_EN is defined.
module input_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic pin,
  output logic q
);
  logic s1_q, s2_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= pin;
      s2_q <= s1_q;
    end
  end

`ifdef MMIO_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          q_q, q_d;

  // Count consecutive samples that disagree with the filtered value; any agreement restarts the count.
  always_comb begin
    cnt_d = '0;
    q_d   = q_q;
    if (s2_q != q_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) q_d = s2_q;
      else                                   cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      q_q   <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      q_q   <= q_d;
    end
  end

  assign q = q_q;
`else
  localparam int unused_debounce = DEBOUNCE_CYCLES;
  assign q = s2_q;
`endif
endmodule

// File: rtl/mmio_responder.sv
// MMIO target: decodes a 32-byte window, stalls LATENCY+1 cycles, then completes against GPIO/timer regs.
// Optional input filtering is enabled with MMIO_DEBOUNCE_EN.
module mmio_responder
  import mmio_responder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR       = 32'h0000_2000,
  parameter int          LATENCY         = 1,
  parameter int          DEBOUNCE_CYCLES = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic [31:0] input_data,
  input  logic        mem_read,
  input  logic        mem_write,
  output logic [31:0] output_data,
  output logic        stall,
  input  logic [3:0]  input_peripherals,
  output logic [3:0]  output_peripherals
);
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic [3:0]  gpio_out_q, gpio_out_d;
  logic [31:0] timer_q, timer_d;
  logic [31:0] cmp_q, cmp_d;
  logic        match_q, match_d;

  logic        sel, req, commit, wr;
  logic [2:0]  offset;
  logic [31:0] rmux;
  logic [3:0]  gpio_in;
  logic        unused_addr;

  assign sel         = address[31:5] == BASE_ADDR[31:5];
  assign req         = sel && (mem_read || mem_write);
  assign offset      = address[4:2];
  assign unused_addr = ^address[1:0];

  for (genvar i = 0; i < 4; i++) begin : g_in
    input_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clock (clock),
      .reset (reset),
      .pin   (input_peripherals[i]),
      .q     (gpio_in[i])
    );
  end

  // The edge that enters DONE both captures the old value and commits the write.
  assign commit = (state_q == ST_WAIT) && req && (cnt_q == 4'd0);
  assign wr     = commit && mem_write;

  always_comb begin
    rmux = '0;
    case (offset)
      MMIO_GPIO_OUT:  rmux[3:0] = gpio_out_q;
      MMIO_GPIO_IN:   rmux[3:0] = gpio_in;
      MMIO_TIMER:     rmux      = timer_q;
      MMIO_TIMER_CMP: rmux      = cmp_q;
      MMIO_STATUS:    rmux[MMIO_STATUS_MATCH] = match_q;
      default:        rmux      = '0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rdata_d    = '0;
    gpio_out_d = gpio_out_q;
    timer_d    = timer_q + 32'd1;
    cmp_d      = cmp_q;
    match_d    = match_q;

    case (state_q)
      ST_IDLE: if (req) begin
        state_d = ST_WAIT;
        cnt_d   = LAT_M1;
      end
      ST_WAIT: begin
        if (!req)             state_d = ST_IDLE;
        else if (commit) begin
          state_d = ST_DONE;
          rdata_d = rmux;
        end else              cnt_d = cnt_q - 4'd1;
      end
      default: state_d = ST_IDLE;
    endcase

    if (wr) begin
      case (offset)
        MMIO_GPIO_OUT:  gpio_out_d = input_data[3:0];
        MMIO_TIMER:     timer_d    = input_data;
        MMIO_TIMER_CMP: cmp_d      = input_data;
        MMIO_STATUS:    if (input_data[MMIO_STATUS_MATCH]) match_d = 1'b0;
        default: ;
      endcase
    end
    // A compare hit wins over a clear landing in the same cycle.
    if (timer_q == cmp_q) match_d = 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      rdata_q    <= '0;
      gpio_out_q <= '0;
      timer_q    <= '0;
      cmp_q      <= 32'hFFFF_FFFF;
      match_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rdata_q    <= rdata_d;
      gpio_out_q <= gpio_out_d;
      timer_q    <= timer_d;
      cmp_q      <= cmp_d;
      match_q    <= match_d;
    end
  end

  assign stall              = !reset && req && (state_q != ST_DONE);
  assign output_data        = rdata_q;
  assign output_peripherals = gpio_out_q;
endmodule

// File: tb/tb_mmio_responder.sv
// Randomized bench for mmio_responder against a transaction-age reference model, plus directed literal checks.
module tb_mmio_responder;
  localparam logic [31:0] BASE = 32'h0000_2000;
  localparam int          LAT  = 3;
  localparam int          DB   = 16;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] address = '0, input_data = '0;
  logic        mem_read = 1'b0, mem_write = 1'b0;
  logic [3:0]  input_peripherals = '0;
  logic [31:0] output_data;
  logic        stall;
  logic [3:0]  output_peripherals;

  int n_cmp = 0;
  int n_bad = 0;

  mmio_responder #(.BASE_ADDR(BASE), .LATENCY(LAT), .DEBOUNCE_CYCLES(DB)) dut (
    .clock              (clock),
    .reset              (reset),
    .address            (address),
    .input_data         (input_data),
    .mem_read           (mem_read),
    .mem_write          (mem_write),
    .output_data        (output_data),
    .stall              (stall),
    .input_peripherals  (input_peripherals),
    .output_peripherals (output_peripherals)
  );

  always #5 clock = ~clock;

  // Reference model: an access is tracked by its age (cycles the request has been held).
  // Age LAT+1 is the completion cycle; the write lands on the edge that reaches it.
  int          m_age;
  logic [31:0] m_odata, m_timer, m_cmp;
  logic [3:0]  m_gpio, m_h1, m_h2;
  logic        m_match;
  int          n_age;
  logic [31:0] n_odata, n_timer, n_cmp_r, rv;
  logic [3:0]  n_gpio, b_gi;
  logic        n_match, b_req, b_commit, b_wr;
  logic [2:0]  b_off;
`ifdef MMIO_DEBOUNCE_EN
  logic [3:0]  m_gi, n_gi;
  int          m_db[4], n_db[4];
`endif

  always_comb begin
    b_req    = (address[31:5] == BASE[31:5]) && (mem_read || mem_write);
    b_off    = address[4:2];
    b_commit = b_req && (m_age == LAT);
    b_wr     = b_commit && mem_write;
`ifdef MMIO_DEBOUNCE_EN
    b_gi = m_gi;
    n_gi = m_gi;
    for (int b = 0; b < 4; b++) begin
      n_db[b] = 0;
      if (m_h2[b] != m_gi[b]) begin
        if (m_db[b] == DB - 1) n_gi[b] = m_h2[b];
        else                   n_db[b] = m_db[b] + 1;
      end
    end
`else
    b_gi = m_h2;
`endif
    case (b_off)
      3'd0:    rv = {28'd0, m_gpio};
      3'd1:    rv = {28'd0, b_gi};
      3'd2:    rv = m_timer;
      3'd3:    rv = m_cmp;
      3'd4:    rv = {31'd0, m_match};
      default: rv = 32'd0;
    endcase
    n_odata = b_commit ? rv : 32'd0;
    n_age   = (!b_req || m_age == LAT + 1) ? 0 : m_age + 1;
    n_gpio  = (b_wr && b_off == 3'd0) ? input_data[3:0] : m_gpio;
    n_timer = (b_wr && b_off == 3'd2) ? input_data : m_timer + 32'd1;
    n_cmp_r = (b_wr && b_off == 3'd3) ? input_data : m_cmp;
    n_match = m_match;
    if (b_wr && b_off == 3'd4 && input_data[0]) n_match = 1'b0;
    if (m_timer == m_cmp) n_match = 1'b1;
  end

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_age <= 0; m_odata <= '0; m_gpio <= '0; m_timer <= '0;
      m_cmp <= 32'hFFFF_FFFF; m_match <= 1'b0; m_h1 <= '0; m_h2 <= '0;
`ifdef MMIO_DEBOUNCE_EN
      m_gi <= '0;
      for (int b = 0; b < 4; b++) m_db[b] <= 0;
`endif
    end else begin
      m_age <= n_age; m_odata <= n_odata; m_gpio <= n_gpio; m_timer <= n_timer;
      m_cmp <= n_cmp_r; m_match <= n_match; m_h1 <= input_peripherals; m_h2 <= m_h1;
`ifdef MMIO_DEBOUNCE_EN
      m_gi <= n_gi;
      for (int b = 0; b < 4; b++) m_db[b] <= n_db[b];
`endif
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model, sampled on the falling edge.
  initial forever begin
    @(negedge clock);
    chk("stall", {31'd0, stall}, {31'd0, !reset && b_req && (m_age != LAT + 1)});
    chk("output_data", output_data, m_odata);
    chk("output_peripherals", {28'd0, output_peripherals}, {28'd0, m_gpio});
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Holds a request until stall drops, returns the DONE-cycle data and the stall cycle count.
  task automatic access(input logic [31:0] a, input logic [31:0] d, input logic r, input logic w,
                        output logic [31:0] got, output int ns);
    address = a; input_data = d; mem_read = r; mem_write = w;
    ns = 0;
    got = '0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (!stall) break;
      ns++;
    end
    if (ns >= 40) chk("stall_timeout", 32'(ns), 32'(LAT + 1));
    got = output_data;
    tick();
    mem_read = 1'b0; mem_write = 1'b0;
  endtask

  logic [31:0] got;
  int          ns;

  initial begin
    // Request held during reset must not stall.
    address = BASE; input_data = 32'hF; mem_write = 1'b1;
    repeat (2) @(negedge clock);
    chk("stall_in_reset", {31'd0, stall}, 32'd0);
    chk("reset_output_data", output_data, 32'd0);
    mem_write = 1'b0;
    tick();
    reset = 1'b0;
    tick();

    access(BASE + 32'd12, 32'd0, 1'b1, 1'b0, got, ns);
    chk("reset_timer_cmp", got, 32'hFFFF_FFFF);
    access(BASE + 32'd0, 32'd0, 1'b1, 1'b0, got, ns);
    chk("reset_gpio_out", got, 32'd0);

    access(BASE + 32'd0, 32'hA, 1'b0, 1'b1, got, ns);
    chk("write_stall_cycles", 32'(ns), 32'(LAT + 1));
    chk("gpio_pins", {28'd0, output_peripherals}, 32'hA);
    access(BASE + 32'd0, 32'd0, 1'b1, 1'b0, got, ns);
    chk("read_gpio_out", got, 32'h0000_000A);

    input_peripherals = 4'h5;
`ifdef MMIO_DEBOUNCE_EN
    repeat (DB + 6) tick();
`else
    repeat (4) tick();
`endif
    access(BASE + 32'd4, 32'd0, 1'b1, 1'b0, got, ns);
    chk("read_gpio_in", got, 32'h5);
    input_peripherals = 4'h0;
    repeat (8) tick();
    input_peripherals = 4'h5;
    repeat (4) tick();
    access(BASE + 32'd4, 32'd0, 1'b1, 1'b0, got, ns);
    chk("gpio_in_after_glitch", got, 32'h5);

    access(BASE + 32'd12, 32'h1, 1'b0, 1'b1, got, ns);
    access(BASE + 32'd8, 32'hFFFF_FFFE, 1'b0, 1'b1, got, ns);
    access(BASE + 32'd16, 32'd0, 1'b1, 1'b0, got, ns);
    chk("match_after_wrap", got, 32'h1);
    access(BASE + 32'd16, 32'h1, 1'b0, 1'b1, got, ns);
    access(BASE + 32'd16, 32'd0, 1'b1, 1'b0, got, ns);
    chk("match_cleared", got, 32'h0);

    access(BASE + 32'd12, 32'h33, 1'b0, 1'b1, got, ns);
    access(BASE + 32'd12, 32'h55, 1'b1, 1'b1, got, ns);
    chk("rmw_old_value", got, 32'h33);
    access(BASE + 32'd12, 32'd0, 1'b1, 1'b0, got, ns);
    chk("rmw_new_value", got, 32'h55);

    access(BASE + 32'h20, 32'd0, 1'b1, 1'b0, got, ns);
    chk("outside_stall_cycles", 32'(ns), 32'd0);
    chk("outside_data", got, 32'd0);
    access(BASE + 32'h1C, 32'd0, 1'b1, 1'b0, got, ns);
    chk("reserved_read", got, 32'd0);

    // Request withdrawn mid-wait leaves GPIO_OUT alone.
    address = BASE; input_data = 32'hF; mem_write = 1'b1;
    repeat (2) tick();
    mem_write = 1'b0;
    repeat (4) tick();
    chk("dropped_write", {28'd0, output_peripherals}, 32'hA);

    // Reset arriving mid-wait aborts the access immediately.
    address = BASE; input_data = 32'h3; mem_write = 1'b1;
    repeat (2) tick();
    #2 reset = 1'b1;
    #1 chk("stall_reset_mid_wait", {31'd0, stall}, 32'd0);
    mem_write = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    chk("gpio_after_reset", {28'd0, output_peripherals}, 32'h0);

    for (int k = 0; k < 150; k++) begin
      logic [31:0] a;
      logic        r, w;
      if ($urandom_range(0, 3) == 0) input_peripherals = 4'($urandom);
      a = BASE + 32'($urandom_range(0, 7)) * 32'd4;
      if ($urandom_range(0, 9) == 0) a = BASE + 32'h20 + 32'($urandom_range(0, 7)) * 32'd4;
      r = 1'($urandom);
      w = 1'($urandom);
      if (!r && !w) r = 1'b1;
      if ($urandom_range(0, 4) == 0) begin
        address = a; input_data = $urandom; mem_read = r; mem_write = w;
        repeat ($urandom_range(1, LAT)) tick();
        mem_read = 1'b0; mem_write = 1'b0;
      end else begin
        access(a, $urandom, r, w, got, ns);
      end
      repeat ($urandom_range(0, 2)) tick();
    end

    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
